hms_timer: RTL
==============

// Module: hms_timer
// PURPOSE
//  Parametrised hour/minute/second time-of-day counter. Successor to the plain
//  second/minute counter: adds an hour field, configurable field limits,
//  tick-enable, run/pause, synchronous clear and load, alarm compare, and a
//  wrap-or-halt mode. Sits beside the system tick divider and feeds display
//  and alarm logic.
// PARAMETERS
//  SEC_MAX  59  last second value before rollover (field counts 0..SEC_MAX)
//  MIN_MAX  59  last minute value before rollover
//  HR_MAX   23  last hour value before rollover
//  WRAP     1   1: roll from full to 00:00:00; 0: halt at full and assert done
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  tick       in   1   one-cycle count-enable strobe (one per second)
//  run        in   1   1 = counting enabled, 0 = paused (hold)
//  clr        in   1   synchronous clear to 00:00:00, clears done
//  load       in   1   synchronous load of ld_hr/ld_min/ld_sec, clears done
//  ld_sec     in   6   load value, seconds
//  ld_min     in   6   load value, minutes
//  ld_hr      in   5   load value, hours
//  alm_en     in   1   alarm compare enable
//  alm_sec    in   6   alarm seconds
//  alm_min    in   6   alarm minutes
//  alm_hr     in   5   alarm hours
//  second     out  6   current seconds, registered
//  minute     out  6   current minutes, registered
//  hour       out  5   current hours, registered
//  min_pulse  out  1   1-cycle pulse: second field rolled over this edge
//  hr_pulse   out  1   1-cycle pulse: minute field rolled over this edge
//  alarm      out  1   1-cycle pulse: counter advanced onto alarm value
//  done       out  1   WRAP=0 only: level, counter halted at full value
// BEHAVIOUR
//  - Reset: second=minute=hour=0, min_pulse=hr_pulse=alarm=done=0.
//  - Priority per edge: clr > load > advance > hold.
//  - advance = run & tick & ~done & ~clr & ~load. Outputs update on that edge
//    (latency 1 clk from tick); tick with run=0 is discarded, not queued.
//  - Advance: sec<SEC_MAX -> sec+1. sec==SEC_MAX -> sec=0, min_pulse=1,
//    and min+1, or min=0 with hr_pulse=1 if min==MIN_MAX, in which case
//    hr+1, or hr=0 if hr==HR_MAX.
//  - Full value = HR_MAX:MIN_MAX:SEC_MAX. WRAP=1: advance from full -> 0:0:0
//    with min_pulse=hr_pulse=1 and done stays 0. WRAP=0: advance from full ->
//    fields hold, done=1, no pulses. Further ticks are ignored until clr/load.
//  - Load: each field clamped independently to its MAX if ld value > MAX.
//    Load/clr produce no pulses and no alarm.
//  - alarm = alm_en & advance & (next value == alarm value) for one cycle.
//    An alarm value > MAX never matches. A halted WRAP=0 counter never alarms.
//  - Pulses are 0 on every edge without advance. No field ever exceeds MAX.
//  - Reset asserted mid-count forces reset values immediately; counting
//    resumes on the first qualifying tick after release.
// TESTING
//  1 reset, run=1, 61 ticks -> 00:01:01, min_pulse once at tick 60, alarm 0.
//  2 load 23:59:58, WRAP=1, 2 ticks -> 00:00:00, min_pulse=hr_pulse=1 on 2nd.
//  3 WRAP=0, load 23:59:59, tick -> fields hold, done=1; 3 more ticks hold;
//    clr -> 00:00:00, done=0.
//  4 alm 00:00:05, alm_en=1, from 0, 5 ticks -> alarm 1 cycle after 5th;
//    load 00:00:05 -> no alarm.
//  5 run=0 with 10 ticks -> unchanged; clr+load+tick on same edge -> 00:00:00.
//  6 load ld_sec=63, ld_hr=31 -> second=59, hour=23; rst_n low mid-count -> 0.

Source files
------------

// File: rtl/hms_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hms_timer : hour/minute/second time-of-day counter with alarm          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module hms_timer #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23,
  parameter int WRAP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       run,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] ld_sec,
  input  logic [5:0] ld_min,
  input  logic [4:0] ld_hr,
  input  logic       alm_en,
  input  logic [5:0] alm_sec,
  input  logic [5:0] alm_min,
  input  logic [4:0] alm_hr,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic       min_pulse,
  output logic       hr_pulse,
  output logic       alarm,
  output logic       done
);

  localparam logic [5:0] SEC_LIM      = 6'(SEC_MAX);
  localparam logic [5:0] MIN_LIM      = 6'(MIN_MAX);
  localparam logic [4:0] HR_LIM       = 5'(HR_MAX);
  localparam bit         HALT_AT_FULL = (WRAP == 0);

  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       min_pulse_q, min_pulse_d;
  logic       hr_pulse_q, hr_pulse_d;
  logic       alarm_q, alarm_d;
  logic       done_q, done_d;

  logic       advance, sec_roll, min_roll, at_full, alm_match;
  logic [5:0] sec_nxt, min_nxt;
  logic [4:0] hr_nxt;

  assign advance  = run & tick & ~done_q & ~clr & ~load;
  assign sec_roll = (sec_q == SEC_LIM);
  assign min_roll = sec_roll & (min_q == MIN_LIM);
  assign at_full  = min_roll & (hr_q == HR_LIM);

  assign sec_nxt = sec_roll ? 6'd0 : sec_q + 6'd1;
  assign min_nxt = sec_roll ? ((min_q == MIN_LIM) ? 6'd0 : min_q + 6'd1) : min_q;
  assign hr_nxt  = min_roll ? ((hr_q == HR_LIM) ? 5'd0 : hr_q + 5'd1) : hr_q;

  // The next value never exceeds its limit, so an out-of-range alarm field cannot match.
  assign alm_match = alm_en && (alm_sec == sec_nxt) && (alm_min == min_nxt)
                     && (alm_hr == hr_nxt);

  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    done_d      = done_q;
    min_pulse_d = 1'b0;
    hr_pulse_d  = 1'b0;
    alarm_d     = 1'b0;
    if (clr) begin
      sec_d  = 6'd0;
      min_d  = 6'd0;
      hr_d   = 5'd0;
      done_d = 1'b0;
    end else if (load) begin
      sec_d  = (ld_sec > SEC_LIM) ? SEC_LIM : ld_sec;
      min_d  = (ld_min > MIN_LIM) ? MIN_LIM : ld_min;
      hr_d   = (ld_hr > HR_LIM) ? HR_LIM : ld_hr;
      done_d = 1'b0;
    end else if (advance) begin
      if (HALT_AT_FULL && at_full) begin
        done_d = 1'b1;
      end else begin
        sec_d       = sec_nxt;
        min_d       = min_nxt;
        hr_d        = hr_nxt;
        min_pulse_d = sec_roll;
        hr_pulse_d  = min_roll;
        alarm_d     = alm_match;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hr_q        <= 5'd0;
      min_pulse_q <= 1'b0;
      hr_pulse_q  <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      min_pulse_q <= min_pulse_d;
      hr_pulse_q  <= hr_pulse_d;
      alarm_q     <= alarm_d;
      done_q      <= done_d;
    end
  end

  assign second    = sec_q;
  assign minute    = min_q;
  assign hour      = hr_q;
  assign min_pulse = min_pulse_q;
  assign hr_pulse  = hr_pulse_q;
  assign alarm     = alarm_q;
  assign done      = done_q;

endmodule
`default_nettype wire
